// File: rtl/his_peak_reader_pkg.sv
// Shared sizes, state encoding and helpers for the histogram peak reader.
// Sizes must match the histogram builder that fills the same SRAM.
package his_peak_reader_pkg;

   localparam int NB        = 8;
   localparam int BIN_NUM   = 256;
   localparam int PIXEL_NUM = 4;
   localparam int PIX_W     = $clog2(PIXEL_NUM);
   localparam int RAM_ADDR  = 10;
   localparam int PEAK_W    = 16;

   // Port B read enable is active low
   localparam logic RD_EN_ACTIVE = 1'b0;
   localparam logic RD_EN_IDLE   = 1'b1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef struct packed {
      logic [PIX_W-1:0]  pixel;
      logic [NB-1:0]     bin;
      logic [PEAK_W-1:0] count;
      logic              found;
   } peakRes_t;

   function automatic logic [RAM_ADDR-1:0] binAddr(input logic [PIX_W-1:0] pix,
                                                   input logic [NB-1:0]    bin);
      return RAM_ADDR'({pix, bin});
   endfunction

endpackage

// File: rtl/his_peak_reader_peak_tracker.sv
// Running maximum of returned bin counts for one pixel histogram.
// The first word after clear loads unconditionally; later words must be strictly greater.
module his_peak_reader_peak_tracker
   import his_peak_reader_pkg::*;
(
   input  logic              clk,
   input  logic              res,
   input  logic              clear,
   input  logic              valid,
   input  logic [NB-1:0]     bin,
   input  logic [PEAK_W-1:0] count,
   output logic [NB-1:0]     maxBin,
   output logic [PEAK_W-1:0] maxCnt
);

   logic first_r;

   // Strict compare keeps the lowest bin index on ties
   always_ff @(posedge clk) begin
      if (res) begin
         first_r <= 1'b1;
         maxBin  <= '0;
         maxCnt  <= '0;
      end else if (clear) begin
         first_r <= 1'b1;
         maxBin  <= '0;
         maxCnt  <= '0;
      end else if (valid && (first_r || (count > maxCnt))) begin
         first_r <= 1'b0;
         maxBin  <= bin;
         maxCnt  <= count;
      end else begin
         first_r <= first_r;
         maxBin  <= maxBin;
         maxCnt  <= maxCnt;
      end
   end

endmodule

// File: rtl/his_peak_reader.sv
// Scans every pixel histogram through SRAM port B and reports the peak bin per pixel,
// followed by a single done pulse.
module his_peak_reader
   import his_peak_reader_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic                clk,
   input  logic                res,
   input  logic                start,
   input  logic [PEAK_W-1:0]   counts,
   output logic [RAM_ADDR-1:0] raddr,
   output logic                rEnable,
   output logic                readFlag,
   output logic                busy,
   output logic                peak_valid,
   output logic [PIX_W-1:0]    peak_pixel,
   output logic [NB-1:0]       peak_bin,
   output logic [PEAK_W-1:0]   peak_count,
   output logic                peak_found,
   output logic                done
);

   localparam logic [NB-1:0]    LAST_BIN = NB'(BIN_NUM - 1);
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);

   logic [2:0]        state_r;
   logic [PIX_W-1:0]  pix_r;
   logic [NB-1:0]     bin_r;
   logic [RD_LAT-1:0] vld_r;
   logic [NB-1:0]     tag_r [RD_LAT];

   logic              clear_s;
   logic [PIX_W-1:0]  pixNext_s;
   logic [NB-1:0]     maxBin_s;
   logic [PEAK_W-1:0] maxCnt_s;
   peakRes_t          result_s;

   assign clear_s   = ((state_r == ST_IDLE) && start) ||
                      ((state_r == ST_EMIT) && (pix_r != LAST_PIX));
   assign pixNext_s = pix_r + PIX_W'(1'b1);
   assign result_s  = '{pixel: pix_r, bin: maxBin_s, count: maxCnt_s,
                        found: (maxCnt_s != '0)};

   his_peak_reader_peak_tracker u_tracker (
      .clk    (clk),
      .res    (res),
      .clear  (clear_s),
      .valid  (vld_r[RD_LAT-1]),
      .bin    (tag_r[RD_LAT-1]),
      .count  (counts),
      .maxBin (maxBin_s),
      .maxCnt (maxCnt_s)
   );

   // Tag each issued read with its bin so the tracker knows which bin returned
   always_ff @(posedge clk) begin
      if (res) begin
         vld_r <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_r[i] <= '0;
      end else begin
         vld_r[0] <= readFlag;
         tag_r[0] <= raddr[NB-1:0];
         for (int i = 1; i < RD_LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   // Scan sequencer; all port B controls and result outputs are registered here
   always_ff @(posedge clk) begin
      if (res) begin
         state_r    <= ST_IDLE;
         pix_r      <= '0;
         bin_r      <= '0;
         raddr      <= '0;
         rEnable    <= RD_EN_IDLE;
         readFlag   <= 1'b0;
         busy       <= 1'b0;
         peak_valid <= 1'b0;
         {peak_pixel, peak_bin, peak_count, peak_found} <= '0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r  <= ST_ISSUE;
                  pix_r    <= '0;
                  bin_r    <= '0;
                  raddr    <= binAddr('0, '0);
                  rEnable  <= RD_EN_ACTIVE;
                  readFlag <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (bin_r == LAST_BIN) begin
                  state_r  <= ST_DRAIN;
                  rEnable  <= RD_EN_IDLE;
                  readFlag <= 1'b0;
               end else begin
                  bin_r <= bin_r + NB'(1'b1);
                  raddr <= binAddr(pix_r, bin_r + NB'(1'b1));
               end
            end
            ST_DRAIN: begin
               if (vld_r == '0) begin
                  state_r    <= ST_EMIT;
                  peak_valid <= 1'b1;
                  {peak_pixel, peak_bin, peak_count, peak_found} <= result_s;
               end
            end
            ST_EMIT: begin
               peak_valid <= 1'b0;
               if (pix_r == LAST_PIX) begin
                  state_r <= ST_DONE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  state_r  <= ST_ISSUE;
                  pix_r    <= pixNext_s;
                  bin_r    <= '0;
                  raddr    <= binAddr(pixNext_s, '0);
                  rEnable  <= RD_EN_ACTIVE;
                  readFlag <= 1'b1;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               rEnable  <= RD_EN_IDLE;
               readFlag <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_his_peak_reader.sv
// Self-checking bench for his_peak_reader: SRAM model, table vectors, random scans
// against a max-then-lowest-index reference, restart and mid-scan reset sequences.
module tb_his_peak_reader;
   import his_peak_reader_pkg::*;

   localparam int RD_LAT   = 1;
   localparam int PIX_CYC  = BIN_NUM + RD_LAT + 2;
   localparam int SCAN_CYC = PIXEL_NUM * PIX_CYC;

   logic                clk = 1'b0;
   logic                res;
   logic                start;
   logic [PEAK_W-1:0]   counts;
   logic [RAM_ADDR-1:0] raddr;
   logic                rEnable, readFlag, busy, peak_valid, peak_found, done;
   logic [PIX_W-1:0]    peak_pixel;
   logic [NB-1:0]       peak_bin;
   logic [PEAK_W-1:0]   peak_count;

   his_peak_reader #(.RD_LAT(RD_LAT)) dut (
      .clk(clk), .res(res), .start(start), .counts(counts), .raddr(raddr),
      .rEnable(rEnable), .readFlag(readFlag), .busy(busy), .peak_valid(peak_valid),
      .peak_pixel(peak_pixel), .peak_bin(peak_bin), .peak_count(peak_count),
      .peak_found(peak_found), .done(done)
   );

   always #5 clk = ~clk;

   logic [PEAK_W-1:0] mem [BIN_NUM*PIXEL_NUM];

   // Single-cycle-latency SRAM port B
   always @(posedge clk) begin
      if (readFlag && (rEnable == 1'b0)) counts <= mem[raddr];
   end

   typedef struct { int pix; int bin; int cnt; int found; int t; } res_t;
   typedef struct {
      int pixSel; int binA; int binB;
      logic [PEAK_W-1:0] valA; logic [PEAK_W-1:0] valB; logic [PEAK_W-1:0] bg;
      int expBin; logic [PEAK_W-1:0] expCnt;
   } vec_t;

   res_t results[$];
   vec_t vecs[5];
   int   checks = 0, failures = 0;
   int   doneCnt, expAddr, readErrs, nReads, tickCount = 0, startTick, doneAt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tickCount++;
      if (peak_valid) begin
         results.push_back('{int'(peak_pixel), int'(peak_bin), int'(peak_count),
                             int'(peak_found), tickCount});
         if (readFlag) readErrs++;
      end
      if (done) doneCnt++;
      if (readFlag) begin
         if ((rEnable !== 1'b0) || (raddr !== RAM_ADDR'(expAddr))) readErrs++;
         expAddr++;
         nReads++;
      end else if (rEnable !== 1'b1) begin
         readErrs++;
      end
   endtask

   // Reference: highest value in the histogram, then the lowest bin holding it
   task automatic modelPeak(input int p, output int bin, output int cnt);
      int mx = 0;
      for (int b = 0; b < BIN_NUM; b++)
         if (int'(mem[p*BIN_NUM+b]) > mx) mx = int'(mem[p*BIN_NUM+b]);
      bin = 0;
      for (int b = BIN_NUM - 1; b >= 0; b--)
         if (int'(mem[p*BIN_NUM+b]) == mx) bin = b;
      cnt = mx;
   endtask

   task automatic checkResults(input string tag);
      int eb, ec;
      check({tag, "_nres"}, results.size(), PIXEL_NUM);
      for (int p = 0; p < results.size() && p < PIXEL_NUM; p++) begin
         modelPeak(p, eb, ec);
         check({tag, "_pix"},   results[p].pix,   p);
         check({tag, "_bin"},   results[p].bin,   eb);
         check({tag, "_cnt"},   results[p].cnt,   ec);
         check({tag, "_found"}, results[p].found, (ec != 0) ? 1 : 0);
      end
      if (results.size() >= 2) begin
         check({tag, "_lat0"},    results[0].t - startTick, BIN_NUM + RD_LAT + 1);
         check({tag, "_spacing"}, results[1].t - results[0].t, PIX_CYC);
      end
   endtask

   task automatic runScan(input string tag, input int restartAt);
      int cyc;
      results.delete();
      doneCnt = 0; expAddr = 0; readErrs = 0; nReads = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      startTick = tickCount;
      check({tag, "_busy_start"}, busy, 1);
      cyc = 0;
      while (doneCnt == 0 && cyc < SCAN_CYC + 100) begin
         if (cyc == restartAt) start = 1'b1;
         tick();
         start = 1'b0;
         cyc++;
      end
      doneAt = cyc;
      for (int i = 0; i < 20; i++) tick();
      check({tag, "_done_cnt"},  doneCnt, 1);
      check({tag, "_addr_errs"}, readErrs, 0);
      check({tag, "_reads"},     nReads, PIXEL_NUM * BIN_NUM);
      check({tag, "_busy_end"},  busy, 0);
      check({tag, "_hold_pix"},  peak_pixel, PIXEL_NUM - 1);
      checkResults(tag);
   endtask

   task automatic fillRandom();
      for (int i = 0; i < BIN_NUM * PIXEL_NUM; i++) begin
         if ($urandom_range(0, 99) == 0) mem[i] = 16'hFFFF;
         else mem[i] = PEAK_W'($urandom_range(0, 20));
      end
   endtask

   initial begin
      vecs[0] = '{2, 17,  200, 16'd40,   16'd40,   16'd3, 17,  16'd40};
      vecs[1] = '{1, 0,   5,   16'hFFFF, 16'hFFFF, 16'd0, 0,   16'hFFFF};
      vecs[2] = '{3, 255, 255, 16'd7,    16'd7,    16'd0, 255, 16'd7};
      vecs[3] = '{0, 0,   0,   16'd0,    16'd0,    16'd0, 0,   16'd0};
      vecs[4] = '{1, 128, 64,  16'd1,    16'd1,    16'd0, 64,  16'd1};

      res = 1'b1; start = 1'b0;
      repeat (3) tick();
      res = 1'b0;
      check("rst_rEnable", rEnable, 1);
      check("rst_readFlag", readFlag, 0);
      check("rst_raddr", raddr, 0);
      check("rst_busy", busy, 0);
      check("rst_outs", {peak_valid, done, peak_pixel, peak_bin, peak_count, peak_found}, 0);
      tick();

      // Ramp on pixel 0, zeros elsewhere, with exact scan time
      for (int i = 0; i < BIN_NUM * PIXEL_NUM; i++) mem[i] = (i < BIN_NUM) ? PEAK_W'(i) : '0;
      runScan("ramp", -1);
      check("ramp_done_time", doneAt, SCAN_CYC);
      if (results.size() > 0) begin
         check("ramp_p0_bin", results[0].bin, 255);
         check("ramp_p0_cnt", results[0].cnt, 255);
         check("ramp_p0_found", results[0].found, 1);
      end

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < BIN_NUM * PIXEL_NUM; i++)
            mem[i] = ((i / BIN_NUM) == vecs[v].pixSel) ? vecs[v].bg : '0;
         mem[vecs[v].pixSel*BIN_NUM + vecs[v].binA] = vecs[v].valA;
         mem[vecs[v].pixSel*BIN_NUM + vecs[v].binB] = vecs[v].valB;
         runScan($sformatf("vec%0d", v), -1);
         if (results.size() > vecs[v].pixSel) begin
            check($sformatf("vec%0d_tbl_bin", v), results[vecs[v].pixSel].bin, vecs[v].expBin);
            check($sformatf("vec%0d_tbl_cnt", v), results[vecs[v].pixSel].cnt, vecs[v].expCnt);
         end
      end

      fillRandom();
      runScan("restart", 100);

      for (int r = 0; r < 2; r++) begin
         fillRandom();
         runScan($sformatf("rand%0d", r), -1);
      end

      // Reset while pixel 1 is being read
      fillRandom();
      results.delete(); doneCnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 2000 && !(readFlag && (raddr >= RAM_ADDR'(BIN_NUM))); c++) tick();
      check("mid_reached_pix1", readFlag && (raddr >= RAM_ADDR'(BIN_NUM)), 1);
      res = 1'b1;
      tick();
      res = 1'b0;
      check("mid_rEnable", rEnable, 1);
      check("mid_busy", busy, 0);
      check("mid_readFlag", readFlag, 0);
      check("mid_pv", peak_valid, 0);
      results.delete(); doneCnt = 0;
      repeat (SCAN_CYC) tick();
      check("mid_no_strobes", results.size() + doneCnt, 0);
      runScan("rescan", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
